// File: rtl/mod_squared_integ.sv
// Streaming |x|^2+|y|^2 with optional low-bit operand masking and non-coherent integration.
// Four-stage pipeline under a single global stall derived from the output handshake.
module mod_squared_integ #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MASK_W = 8,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ACC_W  = 42
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     approx_en,
  input  logic [MASK_W-1:0]        conf_bit_mask,
  input  logic [CNT_W-1:0]         int_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_pwr,
  output logic                     out_sat
);

  localparam int unsigned PW = 2 * DATA_W;

  logic              adv;
  logic [DATA_W-1:0] ax_d, ay_d;

  logic              v1_q, v2_q, v3_q;
  logic [DATA_W-1:0] ax_q, ay_q;
  logic [PW-1:0]     sx_q, sy_q, p_q;
  logic [CNT_W-1:0]  len1_q, len2_q, len3_q;

  logic [CNT_W-1:0]  cnt_q, len_q, cur_len, cnt_inc;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    sum;
  logic              sat_q, sat_d, first, last;
  logic              out_valid_q, out_sat_q;
  logic [ACC_W-1:0]  out_pwr_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_pwr   = out_pwr_q;
  assign out_sat   = out_sat_q;

  // Unsigned magnitude keeps -2^(DATA_W-1) exact as 2^(DATA_W-1).
  always_comb begin
    ax_d = in_x[DATA_W-1] ? (~in_x + 1'b1) : in_x;
    ay_d = in_y[DATA_W-1] ? (~in_y + 1'b1) : in_y;
    if (approx_en) begin
      ax_d[MASK_W-1:0] = ax_d[MASK_W-1:0] & conf_bit_mask;
      ay_d[MASK_W-1:0] = ay_d[MASK_W-1:0] & conf_bit_mask;
    end
  end

  // int_len travels with each sample so the frame length is the one seen at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      ax_q   <= '0;
      ay_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      p_q    <= '0;
      len1_q <= '0;
      len2_q <= '0;
      len3_q <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      ax_q   <= ax_d;
      ay_q   <= ay_d;
      len1_q <= int_len;
      v2_q   <= v1_q;
      sx_q   <= PW'(ax_q) * PW'(ax_q);
      sy_q   <= PW'(ay_q) * PW'(ay_q);
      len2_q <= len1_q;
      v3_q   <= v2_q;
      p_q    <= sx_q + sy_q;
      len3_q <= len2_q;
    end
  end

  always_comb begin
    first   = (cnt_q == '0);
    cur_len = first ? ((len3_q == '0) ? CNT_W'(1) : len3_q) : len_q;
    cnt_inc = cnt_q + CNT_W'(1);
    last    = (cnt_inc == cur_len);
    sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p_q);
    acc_d   = ACC_W'(p_q);
    sat_d   = 1'b0;
    if (!first) begin
      if (sum[ACC_W]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
        sat_d = sat_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_pwr_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= v3_q && last;
      if (v3_q) begin
        acc_q <= acc_d;
        if (last) begin
          out_pwr_q <= acc_d;
          out_sat_q <= sat_d;
          cnt_q     <= '0;
          sat_q     <= 1'b0;
        end else begin
          cnt_q <= cnt_inc;
          sat_q <= sat_d;
          if (first) len_q <= cur_len;
        end
      end
    end
  end

endmodule
